// File: rtl/tff_ctrl_pkg.sv
// Shared types and constants for the T flip-flop bank sequencer.
package tff_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    PRESET = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/tff_toggle_mask.sv
// Toggle vector that advances a T flip-flop bank by one count, up or down.
module tff_toggle_mask
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  output logic [WIDTH-1:0] mask
);

  logic up_c;
  logic dn_c;

  // Bit i toggles when all lower bits are 1 (up) or all are 0 (down).
  always_comb begin
    mask = '0;
    up_c = 1'b1;
    dn_c = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (dir == DIR_DN) ? dn_c : up_c;
      up_c    = up_c & q[i];
      dn_c    = dn_c & ~q[i];
    end
  end

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencer that runs an external T flip-flop bank as an up/down counter
// with a programmable terminal value, one-shot or auto-reload.
//
// state  | meaning
// IDLE   | waiting for start, bank left untouched
// CLEAR  | bank cleared through bank_rst_n
// PRESET | bank loaded with limit_r (down count only)
// RUN    | counting toward terminal value
module tff_count_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int RLD_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 dir,
  input  logic                 auto_rld,
  input  logic [WIDTH-1:0]     limit,
  input  logic [WIDTH-1:0]     q_bank,
  output logic [WIDTH-1:0]     t_en,
  output logic                 bank_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic [RLD_CNT_W-1:0] rld_cnt
);

  state_t           state;
  logic             dir_r;
  logic             auto_r;
  logic [WIDTH-1:0] limit_r;
  logic [WIDTH-1:0] run_mask;
  logic             terminal;

  tff_toggle_mask #(.WIDTH(WIDTH)) u_mask (
    .q    (q_bank),
    .dir  (dir_r),
    .mask (run_mask)
  );

  assign terminal = (state == RUN) &&
                    ((dir_r == DIR_DN) ? (q_bank == '0) : (q_bank == limit_r));

  // The bank is already zero in PRESET, so toggling limit_r loads it.
  always_comb begin
    t_en = '0;
    case (state)
      PRESET:  if (!stop) t_en = limit_r;
      RUN:     if (!stop && !terminal) t_en = run_mask;
      default: t_en = '0;
    endcase
  end

  assign bank_rst_n = rst_n & (state != CLEAR);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      dir_r   <= 1'b0;
      auto_r  <= 1'b0;
      limit_r <= '0;
      done    <= 1'b0;
      rld_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dir_r   <= dir;
            auto_r  <= auto_rld;
            limit_r <= limit;
            rld_cnt <= '0;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          if (stop)                  state <= IDLE;
          else if (dir_r == DIR_DN)  state <= PRESET;
          else                       state <= RUN;
        end
        PRESET: begin
          state <= stop ? IDLE : RUN;
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else if (terminal) begin
            done <= 1'b1;
            if (auto_r) begin
              state <= CLEAR;
              if (rld_cnt != '1) rld_cnt <= rld_cnt + 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Self-checking bench: T flip-flop bank in a feedback loop plus a counter-level model.
module tb_tff_count_ctrl;

  localparam int W  = 4;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          dir = 1'b0;
  logic          auto_rld = 1'b0;
  logic [W-1:0]  limit = '0;
  logic [W-1:0]  q_bank;
  logic [W-1:0]  t_en;
  logic          bank_rst_n;
  logic          busy;
  logic          done;
  logic [RW-1:0] rld_cnt;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  tff_count_ctrl #(.WIDTH(W), .RLD_CNT_W(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .dir        (dir),
    .auto_rld   (auto_rld),
    .limit      (limit),
    .q_bank     (q_bank),
    .t_en       (t_en),
    .bank_rst_n (bank_rst_n),
    .busy       (busy),
    .done       (done),
    .rld_cnt    (rld_cnt)
  );

  // Bank of T flip-flop cells, one per bit, with synchronous clear.
  logic q_cell [W];
  for (genvar i = 0; i < W; i++) begin : g_tff
    always @(posedge clk) begin
      if (!bank_rst_n)  q_cell[i] <= 1'b0;
      else if (t_en[i]) q_cell[i] <= ~q_cell[i];
    end
  end
  always_comb begin
    q_bank = '0;
    for (int i = 0; i < W; i++) q_bank[i] = q_cell[i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 clear, 2 preset, 3 run; counter value tracked arithmetically.
  int           m_ph = 0;
  logic         m_dir = 1'b0;
  logic         m_auto = 1'b0;
  logic [W-1:0] m_lim = '0;
  logic [W-1:0] m_q = '0;
  bit           m_qv = 1'b0;
  bit           m_init = 1'b0;
  bit           m_done = 1'b0;
  int           m_rld = 0;

  always @(negedge clk) begin
    logic [W-1:0] nxt;
    logic [W-1:0] e_t;
    logic         term;
    term = (m_ph == 3) && (m_dir ? (m_q == '0) : (m_q == m_lim));
    nxt  = m_dir ? m_q - 1'b1 : m_q + 1'b1;
    e_t  = '0;
    if (m_ph == 2 && !stop) e_t = m_lim;
    if (m_ph == 3 && !stop && !term) e_t = m_q ^ nxt;
    if (m_init) begin
      chk("t_en", 32'(t_en), 32'(e_t));
      chk("bank_rst_n", 32'(bank_rst_n), 32'(rst_n && m_ph != 1));
      chk("busy", 32'(busy), 32'(m_ph != 0));
      chk("done", 32'(done), 32'(m_done));
      chk("rld_cnt", 32'(rld_cnt), 32'(m_rld));
      if (m_qv) chk("q_bank", 32'(q_bank), 32'(m_q));
    end
    if (done === 1'b1) done_seen++;
    if (!rst_n) begin
      m_ph = 0; m_dir = 1'b0; m_auto = 1'b0; m_lim = '0;
      m_done = 1'b0; m_rld = 0; m_q = '0; m_qv = 1'b1; m_init = 1'b1;
    end else begin
      m_done = 1'b0;
      case (m_ph)
        0: if (start) begin
          m_dir = dir; m_auto = auto_rld; m_lim = limit; m_rld = 0; m_ph = 1;
        end
        1: begin
          m_q  = '0;
          m_ph = stop ? 0 : (m_dir ? 2 : 3);
        end
        2: if (stop) m_ph = 0; else begin m_q = m_lim; m_ph = 3; end
        default: begin
          if (stop) m_ph = 0;
          else if (term) begin
            m_done = 1'b1;
            if (m_auto) begin
              m_ph = 1;
              if (m_rld < (1 << RW) - 1) m_rld = m_rld + 1;
            end else m_ph = 0;
          end else m_q = nxt;
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs are scrambled after the start edge to show they are latched.
  task automatic go(input logic d, input logic a, input logic [W-1:0] l);
    dir = d; auto_rld = a; limit = l; start = 1'b1;
    step();
    start = 1'b0; dir = ~d; limit = ~l; auto_rld = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (done !== 1'b1 && lat < maxc);
    if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
    step();
  endtask

  initial begin
    int lat;
    int d0;
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_t_en", 32'(t_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bank_rst_n", 32'(bank_rst_n), 32'd0);
    chk("rst_rld_cnt", 32'(rld_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // Up one-shot, limit 5
    d0 = done_seen;
    go(1'b0, 1'b0, 4'd5);
    wait_done(30, lat);
    chk("up5_latency", 32'(lat), 32'd8);
    chk("up5_q_end", 32'(q_bank), 32'd5);
    repeat (3) step();
    chk("up5_done_count", 32'(done_seen - d0), 32'd1);
    chk("up5_busy_end", 32'(busy), 32'd0);

    // Down one-shot, limit 9
    go(1'b1, 1'b0, 4'd9);
    step();
    step();
    chk("dn9_preset_q", 32'(q_bank), 32'd9);
    wait_done(30, lat);
    chk("dn9_latency_rest", 32'(lat), 32'd11);
    chk("dn9_q_end", 32'(q_bank), 32'd0);

    // Auto-reload up, limit 2, three periods then stop
    go(1'b0, 1'b1, 4'd2);
    n = 0;
    lat = 0;
    while (n < 3 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) n++;
    end
    chk("auto_done_count", 32'(n), 32'd3);
    chk("auto_rld_cnt", 32'(rld_cnt), 32'd3);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("auto_stop_busy", 32'(busy), 32'd0);
    step();

    // Stop in the terminal cycle, up limit 3
    d0 = done_seen;
    go(1'b0, 1'b0, 4'd3);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (q_bank !== 4'd2 && lat < 20);
    chk("stop_reach_q2", 32'(q_bank), 32'd2);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_t_en", 32'(t_en), 32'd0);
    repeat (3) step();
    chk("stop_q_hold", 32'(q_bank), 32'd3);
    chk("stop_no_done", 32'(done_seen - d0), 32'd0);

    // limit 0 up
    go(1'b0, 1'b0, 4'd0);
    wait_done(10, lat);
    chk("up0_latency", 32'(lat), 32'd3);

    // limit 0 down
    go(1'b1, 1'b0, 4'd0);
    wait_done(10, lat);
    chk("dn0_latency", 32'(lat), 32'd4);

    // All-ones up, no wrap
    go(1'b0, 1'b0, 4'hF);
    wait_done(40, lat);
    chk("up15_latency", 32'(lat), 32'd18);
    repeat (2) step();
    chk("up15_q_no_wrap", 32'(q_bank), 32'd15);

    // start while busy is ignored
    go(1'b0, 1'b0, 4'd6);
    step();
    step();
    dir = 1'b1; limit = 4'd1; auto_rld = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(30, lat);
    chk("busy_start_latency_rest", 32'(lat), 32'd6);
    chk("busy_start_q_end", 32'(q_bank), 32'd6);
    chk("busy_start_idle", 32'(busy), 32'd0);

    // Reset in the middle of RUN
    go(1'b0, 1'b0, 4'd10);
    repeat (4) step();
    chk("midrst_q_before", 32'(q_bank), 32'd3);
    rst_n = 1'b0;
    step();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_q_cleared", 32'(q_bank), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rld_cnt", 32'(rld_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
